wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port (WE3/AD3/WD3) in the pipelined RISC-V core.
- Merges two writeback sources:
  - source A: in-order pipeline writeback; high priority, no backpressure.
  - source B: long-latency unit (load miss / multiply); valid/ready handshake, buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding B results so decode can stall on RAW/WAW.
- Forces a one-cycle pipeline bubble when B is starved.

Parameters:
- ADDRESS_WIDTH, 5, register index width (32 architectural registers).
- DATA_WIDTH, 32, writeback data width.
- FIFO_DEPTH, 4, source-B buffer entries (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive cycles B may lose arbitration before a bubble is forced.

Ports:
- clk  in  1  core clock, posedge logic.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  pipeline writeback present this cycle.
- a_rd  in  ADDRESS_WIDTH  pipeline destination register.
- a_data  in  DATA_WIDTH  pipeline result.
- b_valid  in  1  long-latency result offered.
- b_ready  out  1  FIFO can accept (not full).
- b_rd  in  ADDRESS_WIDTH  long-latency destination.
- b_data  in  DATA_WIDTH  long-latency result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_rd  in  ADDRESS_WIDTH  its destination.
- rs1  in  ADDRESS_WIDTH  decode source register 1 query.
- rs2  in  ADDRESS_WIDTH  decode source register 2 query.
- rs1_busy  out  1  rs1 has an outstanding B result (combinational).
- rs2_busy  out  1  rs2 has an outstanding B result (combinational).
- pipe_stall  out  1  registered request to inject one bubble.
- WE3  out  1  regfile write enable (registered).
- AD3  out  ADDRESS_WIDTH  regfile write address (registered).
- WD3  out  DATA_WIDTH  regfile write data (registered).
- waw_err  out  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: WE3=0, AD3=0, WD3=0, pipe_stall=0, waw_err=0, FIFO empty, b_ready=1, all busy bits 0, starve counter 0.
- FIFO push: at posedge when b_valid && b_ready. b_ready = !full; it does not depend on this cycle's pop.
- Arbitration, each cycle:
  - if a_valid: A selected.
  - else if FIFO non-empty: pop head and select it.
  - else: nothing selected.
- Output register: the selected write is registered into WE3/AD3/WD3, so latency is 1 cycle from input to WE3. Regfile writes on the negedge of that output cycle.
- x0 handling: if the selected rd==0, WE3=0 for that cycle. A B entry with rd 0 is still popped and its scoreboard handling is unchanged (x0 is never marked busy).
- Scoreboard:
  - busy[issue_rd] is set at posedge when issue_valid && issue_rd!=0.
  - busy[r] is cleared at the posedge ending the cycle in which WE3=1 came from B with AD3=r.
  - Simultaneous set and clear of the same r: set wins.
- rsN_busy = busy[rsN]; it is 0 when rsN==0.
- WAW/protocol errors: waw_err is set (sticky until reset) when any of these occur:
  - a_valid with busy[a_rd]=1 and a_rd!=0;
  - issue_valid with busy[issue_rd] already set;
  - b push whose b_rd is not busy.
  - Data is still written as arbitrated.
- Starvation counter:
  - increments each cycle FIFO non-empty && a_valid;
  - clears on any B pop;
  - saturates at STARVE_LIMIT.
- Bubble: when the counter equals STARVE_LIMIT, pipe_stall=1 for exactly one cycle (registered). The pipeline guarantees a_valid=0 in the cycle after pipe_stall, so the head drains then. If a_valid=1 anyway, A still wins and waw_err is set.
- Full FIFO: b_ready=0 and b_valid is held by the producer; no loss.
- Empty FIFO with a_valid=0: WE3=0.
- FIFO pointers wrap modulo FIFO_DEPTH, using one extra pointer bit for full/empty.
- Reset mid-operation: all queued B results and busy bits are discarded. The producer re-issues after reset.

Optional Feature:
- WB_PERF_EN defined adds three outputs, each a 32-bit wrapping counter cleared on reset:
  - perf_b_conflict: cycles where B lost to A;
  - perf_b_full: cycles where b_valid && !b_ready;
  - perf_bubbles: count of pipe_stall pulses.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg:
  - reg_idx_t (logic [ADDRESS_WIDTH-1:0]);
  - wb_entry_t struct {rd, data};
  - X0 constant;
  - default FIFO_DEPTH / STARVE_LIMIT constants.
- Sub-module wb_fifo: parameterised sync FIFO of wb_entry_t with push/pop/full/empty, reused by the arbiter.
- Scoreboard, arbiter and starve counter stay in the top module.

Test Plan:
- Reset then idle → WE3=0, b_ready=1, rs1_busy=0, waw_err=0.
- a_valid=1, a_rd=5, a_data=0xDEADBEEF → next cycle WE3=1, AD3=5, WD3=0xDEADBEEF.
- issue rd=7; two cycles later push b_rd=7, data=0x1234 with a_valid=0 → rs1=7 busy until after WE3=1/AD3=7/WD3=0x1234, then rs1_busy=0.
- Fill FIFO with 4 B entries while a_valid held 1 → b_ready=0 after 4th push. After 8 conflict cycles pipe_stall pulses one cycle. With a_valid=0 next cycle, the head entry writes, counter clears.
- a_valid with a_rd=0 → WE3 stays 0. b entry with rd=0 pops without write.
- issue rd=3 then a_valid a_rd=3 while busy → waw_err=1 and stays 1 until rst_n low.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the register-file writeback port arbiter.
//   ADDRESS_WIDTH / DATA_WIDTH : register index and writeback data widths.
//   reg_idx_t, data_t          : register index and data types.
//   wb_entry_t                 : one writeback request {rd, data}.
//   X0                         : the hard-wired zero register index.
//   DEFAULT_FIFO_DEPTH / DEFAULT_STARVE_LIMIT : default top-level parameters.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int ADDRESS_WIDTH = 5;
  localparam int DATA_WIDTH    = 32;
  localparam int NUM_REGS      = 1 << ADDRESS_WIDTH;

  localparam int DEFAULT_FIFO_DEPTH   = 4;
  localparam int DEFAULT_STARVE_LIMIT = 8;

  typedef logic [ADDRESS_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  typedef struct packed {
    reg_idx_t rd;
    data_t    data;
  } wb_entry_t;

  localparam reg_idx_t X0 = '0;

  function automatic logic is_x0(input reg_idx_t r);
    return r == X0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t used to buffer long-latency writeback results.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push     : write i_entry at the tail (ignored when full)
//   i_entry    : entry to write
//   i_pop      : drop the head entry (ignored when empty)
//   o_head     : current head entry (valid when !o_empty)
//   o_full     : no free slot
//   o_empty    : no stored entry
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  wb_entry_t i_entry,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  wb_entry_t   r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_head    = r_mem[r_rd_ptr[PW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // slots hold valid data, so clearing the contents would only cost area.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_entry;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Owns the single register-file write port (WE3/AD3/WD3). Source A (in-order
// pipeline) always wins; source B (long-latency unit) is buffered in wb_fifo
// and drains when A is idle. A busy scoreboard tracks registers with an
// outstanding B result, and a starvation counter requests a one-cycle bubble
// when B has lost arbitration STARVE_LIMIT times in a row.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   a_valid, a_rd, a_data      : pipeline writeback (no backpressure)
//   b_valid, b_ready, b_rd, b_data : long-latency result handshake
//   issue_valid, issue_rd      : long-latency op issued; marks issue_rd busy
//   rs1, rs2 / rs1_busy, rs2_busy : decode busy queries (combinational)
//   pipe_stall                 : registered one-cycle bubble request
//   WE3, AD3, WD3              : registered regfile write port
//   waw_err                    : sticky protocol-violation flag
// Optional build macro WB_PERF_EN adds 32-bit wrapping counters
//   perf_b_conflict, perf_b_full, perf_bubbles.
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     a_valid,
  input  reg_idx_t a_rd,
  input  data_t    a_data,
  input  logic     b_valid,
  output logic     b_ready,
  input  reg_idx_t b_rd,
  input  data_t    b_data,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     pipe_stall,
  output logic     WE3,
  output reg_idx_t AD3,
  output data_t    WD3,
  output logic     waw_err
`ifdef WB_PERF_EN
  ,
  output logic [31:0] perf_b_conflict,
  output logic [31:0] perf_b_full,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // FIFO interface
  wb_entry_t w_b_entry;
  wb_entry_t w_head;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;
  logic      w_conflict;

  // Arbitration result
  logic      w_sel_valid;
  logic      w_sel_from_b;
  wb_entry_t w_sel;

  // Registered write port and scoreboard state
  logic                r_we3;
  logic                r_we3_from_b;
  reg_idx_t            r_ad3;
  data_t               r_wd3;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic                r_waw_err;
  logic                w_err_now;

  // Starvation / bubble
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_next;
  logic          r_pipe_stall;
  logic          r_bubble_due;

  assign w_b_entry  = '{rd: b_rd, data: b_data};
  assign b_ready    = !w_full;
  assign w_push     = b_valid && !w_full;
  assign w_pop      = !a_valid && !w_empty;
  assign w_conflict = a_valid && !w_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_b_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_from_b = 1'b0;
    w_sel        = '0;
    if (a_valid) begin
      w_sel_valid = 1'b1;
      w_sel       = '{rd: a_rd, data: a_data};
    end else if (!w_empty) begin
      w_sel_valid  = 1'b1;
      w_sel_from_b = 1'b1;
      w_sel        = w_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3        <= 1'b0;
      r_we3_from_b <= 1'b0;
      r_ad3        <= '0;
      r_wd3        <= '0;
    end else begin
      // Writes to x0 are dropped at the port; the B entry is still consumed.
      r_we3        <= w_sel_valid && !is_x0(w_sel.rd);
      r_we3_from_b <= w_sel_from_b && !is_x0(w_sel.rd);
      if (w_sel_valid) begin
        r_ad3 <= w_sel.rd;
        r_wd3 <= w_sel.data;
      end
    end
  end

  // Clear is applied before set so a same-register issue in the retiring
  // cycle keeps the bit busy.
  always_comb begin
    w_busy_next = r_busy;
    if (r_we3_from_b)                         w_busy_next[r_ad3]    = 1'b0;
    if (issue_valid && !is_x0(issue_rd))      w_busy_next[issue_rd] = 1'b1;
  end

  assign w_err_now = (a_valid && !is_x0(a_rd) && r_busy[a_rd]) ||
                     (issue_valid && r_busy[issue_rd])           ||
                     (w_push && !r_busy[b_rd])                   ||
                     (r_bubble_due && a_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_waw_err <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      if (w_err_now) r_waw_err <= 1'b1;
    end
  end

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (w_pop)                                  w_starve_next = '0;
    else if (w_conflict && r_starve_cnt != LIMIT) w_starve_next = r_starve_cnt + 1'b1;
  end

  // The bubble fires only on the transition into the saturated value, which
  // makes it a single-cycle pulse even if A keeps winning afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_pipe_stall <= 1'b0;
      r_bubble_due <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_pipe_stall <= (w_starve_next == LIMIT) && (r_starve_cnt != LIMIT);
      r_bubble_due <= r_pipe_stall;
    end
  end

  assign rs1_busy   = !is_x0(rs1) && r_busy[rs1];
  assign rs2_busy   = !is_x0(rs2) && r_busy[rs2];
  assign pipe_stall = r_pipe_stall;
  assign WE3        = r_we3;
  assign AD3        = r_ad3;
  assign WD3        = r_wd3;
  assign waw_err    = r_waw_err;

`ifdef WB_PERF_EN
  logic [31:0] r_perf_b_conflict;
  logic [31:0] r_perf_b_full;
  logic [31:0] r_perf_bubbles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_b_conflict <= '0;
      r_perf_b_full     <= '0;
      r_perf_bubbles    <= '0;
    end else begin
      if (w_conflict)           r_perf_b_conflict <= r_perf_b_conflict + 1'b1;
      if (b_valid && !b_ready)  r_perf_b_full     <= r_perf_b_full + 1'b1;
      if (r_pipe_stall)         r_perf_bubbles    <= r_perf_bubbles + 1'b1;
    end
  end

  assign perf_b_conflict = r_perf_b_conflict;
  assign perf_b_full     = r_perf_b_full;
  assign perf_bubbles    = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model
// (queues and a busy array) predicts register writes into exp_q; a separate
// monitor pops and compares whenever WE3 is asserted. Status outputs are
// compared against the model every cycle.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_busy, rs2_busy, pipe_stall, WE3, waw_err;
  logic [4:0]  AD3;
  logic [31:0] WD3;
`ifdef WB_PERF_EN
  logic [31:0] perf_b_conflict, perf_b_full, perf_bubbles;
`endif

  wb_port_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .pipe_stall  (pipe_stall),
    .WE3         (WE3),
    .AD3         (AD3),
    .WD3         (WD3),
    .waw_err     (waw_err)
`ifdef WB_PERF_EN
    ,
    .perf_b_conflict (perf_b_conflict),
    .perf_b_full     (perf_b_full),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  ent_t        exp_q[$];
  ent_t        m_q[$];
  bit          m_busy[32];
  int          m_starve;
  bit          m_stall, m_bubble_due, m_err, m_clr_v;
  logic [4:0]  m_clr_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_starve = 0;
    m_stall = 0; m_bubble_due = 0; m_err = 0; m_clr_v = 0; m_clr_rd = '0;
  endtask

  // One clock of behaviour: A wins, else the oldest B result drains; x0 is
  // never written; busy marks registers awaiting a B result.
  task automatic model_update(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                              input bit bv, input logic [4:0] brd, input logic [31:0] bdat,
                              input bit iv, input logic [4:0] ird);
    bit         had;
    bit         push;
    bit         popped;
    bit         from_b;
    int         old;
    logic [4:0] wrd;
    ent_t       e;
    had = (m_q.size() != 0);
    push = bv && (m_q.size() < DEPTH);
    popped = 0; from_b = 0; wrd = '0; old = m_starve;
    if ((av && ard != 0 && m_busy[ard]) || (iv && m_busy[ird]) ||
        (push && !m_busy[brd]) || (m_bubble_due && av)) m_err = 1;
    if (av) begin
      if (ard != 0) exp_q.push_back('{ard, adat});
    end else if (had) begin
      e = m_q.pop_front();
      popped = 1;
      if (e.rd != 0) begin
        exp_q.push_back(e);
        from_b = 1;
        wrd = e.rd;
      end
    end
    if (push) m_q.push_back('{brd, bdat});
    if (m_clr_v) m_busy[m_clr_rd] = 0;
    if (iv && ird != 0) m_busy[ird] = 1;
    m_clr_v = from_b;
    m_clr_rd = wrd;
    if (popped) m_starve = 0;
    else if (had && av && m_starve < LIMIT) m_starve++;
    m_bubble_due = m_stall;
    m_stall = (m_starve == LIMIT) && (old != LIMIT);
  endtask

  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bdat,
                      input bit iv, input logic [4:0] ird,
                      input logic [4:0] q1, input logic [4:0] q2);
    @(negedge clk);
    check("pipe_stall", pipe_stall, m_stall);
    check("waw_err", waw_err, m_err);
    check("b_ready", b_ready, m_q.size() < DEPTH);
    a_valid = av; a_rd = ard; a_data = adat;
    b_valid = bv; b_rd = brd; b_data = bdat;
    issue_valid = iv; issue_rd = ird;
    rs1 = q1; rs2 = q2;
    #1;
    check("rs1_busy", rs1_busy, (q1 != 0) && m_busy[q1]);
    check("rs2_busy", rs2_busy, (q2 != 0) && m_busy[q2]);
    model_update(av, ard, adat, bv, brd, bdat, iv, ird);
  endtask

  task automatic idle(input int n, input logic [4:0] q1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    a_valid = 0; b_valid = 0; issue_valid = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_WE3", WE3, 0);
    check("reset_b_ready", b_ready, 1);
    check("reset_waw_err", waw_err, 0);
    check("reset_pipe_stall", pipe_stall, 0);
  endtask

  // Monitor: every asserted write must match the oldest predicted write.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n && WE3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write_WE3", WE3, 0);
      end else begin
        e = exp_q.pop_front();
        check("write_AD3", AD3, e.rd);
        check("write_WD3", WD3, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    int          pend[$];
    bit          offering;
    logic [4:0]  off_rd, ard, ird;
    logic [31:0] off_data;
    bit          av, iv, ready_now;
    int          bound;

    model_clear();
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd1);

    // Single A write
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // Issue rd 7, B result two cycles later, busy lifts after the write
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    step(0, 0, 0, 1, 5'd7, 32'h1234, 0, 0, 5'd7, 0);
    idle(4, 5'd7);

    // Fill the FIFO under constant A traffic until the bubble is requested
    for (int i = 0; i < 4; i++) step(1, 5'd1, $urandom, 0, 0, 0, 1, 5'(8 + i), 5'(8 + i), 0);
    for (int i = 0; i < 4; i++) step(1, 5'd2, $urandom, 1, 5'(8 + i), 32'hB000 + i, 0, 0, 5'd8, 0);
    bound = 0;
    while (!m_stall && bound < 20) begin
      step(1, 5'd2, $urandom, 0, 0, 0, 0, 0, 5'd8, 0);
      bound++;
    end
    step(1, 5'd2, $urandom, 0, 0, 0, 0, 0, 5'd8, 0);   // pipe_stall cycle
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 0);             // bubble: head drains
    idle(8, 5'd9);

    // x0 from A, then WAW on a busy register, then a B entry to x0
    step(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 0);
    step(1, 5'd3, 32'h3333, 0, 0, 0, 0, 0, 5'd3, 0);
    step(0, 0, 0, 1, 5'd0, 32'h5555, 0, 0, 5'd3, 0);
    idle(3, 0);
    check("waw_sticky", waw_err, 1);
    do_reset();

    // Protocol-respecting random traffic
    offering = 0; off_rd = '0; off_data = '0;
    for (int c = 0; c < 1600; c++) begin
      bit drain;
      drain = (c >= 1500);
      av = !drain && !m_bubble_due &&
           ($urandom_range(0, 99) < (((c / 250) % 2) ? 92 : 55));
      ard = 5'($urandom);
      if (m_busy[ard]) ard = '0;
      iv = !drain && ($urandom_range(0, 99) < 25);
      ird = 5'($urandom);
      if (ird == 0 || m_busy[ird]) iv = 0;
      if (!offering && pend.size() > 0 && $urandom_range(0, 99) < 50) begin
        offering = 1;
        off_rd = 5'(pend.pop_front());
        off_data = $urandom;
      end
      ready_now = (m_q.size() < DEPTH);
      step(av, ard, $urandom, offering, off_rd, off_data, iv, ird,
           5'($urandom), 5'($urandom));
      if (offering && ready_now) offering = 0;
      if (iv) pend.push_back(int'(ird));
    end

    // Unconstrained traffic including protocol violations, then mid-run reset
    for (int c = 0; c < 300; c++) begin
      step($urandom_range(0, 1), 5'($urandom), $urandom,
           $urandom_range(0, 99) < 40, 5'($urandom), $urandom,
           $urandom_range(0, 99) < 30, 5'($urandom),
           5'($urandom), 5'($urandom));
    end
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'($urandom), 5'($urandom));
    step(1, 5'd4, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 0);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
